// File: rtl/instr_receive.sv
// Instruction receive stage: pulls words from the transmit stage over a four-phase
// syn/ack handshake into a local buffer. Optional running XOR via RECEIVE_CHECKSUM_EN.
module instr_receive #(
   parameter int IWIDTH  = 32,
   parameter int DEPTH   = 36,
   parameter int AWIDTH  = 6,
   parameter int TIMEOUT = 16
) (
   input  logic              r_clk,
   input  logic              r_rst,
   input  logic              r_i_start,
   output logic              r_o_syn,
   input  logic              r_i_ack,
   input  logic              r_i_last,
   input  logic [IWIDTH-1:0] r_i_instr,
   input  logic [AWIDTH-1:0] r_i_rd_addr,
   output logic [IWIDTH-1:0] r_o_rd_data,
   output logic [AWIDTH:0]   r_o_count,
   output logic              r_o_busy,
   output logic              r_o_done,
   output logic              r_o_err,
   output logic [1:0]        r_o_err_code,
   output logic [IWIDTH-1:0] r_o_checksum
);

   localparam int TWIDTH = $clog2(TIMEOUT + 1);

   localparam logic [1:0] ERR_NONE     = 2'b00;
   localparam logic [1:0] ERR_TIMEOUT  = 2'b01;
   localparam logic [1:0] ERR_OVERFLOW = 2'b10;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      RELEASE,
      DONE,
      ERR
   } state_t;

   state_t              r_state;
   state_t              w_stateNext;

   logic                r_syn;
   logic                r_busy;
   logic                r_done;
   logic                r_err;
   logic [1:0]          r_errCode;
   logic [AWIDTH:0]     r_count;
   logic [TWIDTH-1:0]   r_timer;
   logic [IWIDTH-1:0]   r_rdData;

   logic                w_synNext;
   logic                w_busyNext;
   logic                w_doneNext;
   logic                w_errNext;
   logic [1:0]          w_errCodeNext;
   logic [AWIDTH:0]     w_countNext;
   logic [TWIDTH-1:0]   w_timerNext;
   logic                w_wrEn;
   logic                w_clrSum;
   logic                w_timerExpired;
   logic                w_lastSlot;
   logic                w_addrValid;

   logic [IWIDTH-1:0]   r_mem [DEPTH];

   assign w_timerExpired = (r_timer == TWIDTH'(TIMEOUT - 1));
   assign w_lastSlot     = ((r_count + (AWIDTH+1)'(1)) == (AWIDTH+1)'(DEPTH));
   assign w_addrValid    = ({1'b0, r_i_rd_addr} < (AWIDTH+1)'(DEPTH));

   // State register
   always_ff @(posedge r_clk) begin
      if (r_rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_stateNext;
      end
   end

   // Next-state and next-output logic; ack beats timer expiry in the same cycle
   always_comb begin
      w_stateNext   = r_state;
      w_synNext     = r_syn;
      w_busyNext    = r_busy;
      w_doneNext    = r_done;
      w_errNext     = r_err;
      w_errCodeNext = r_errCode;
      w_countNext   = r_count;
      w_timerNext   = r_timer;
      w_wrEn        = 1'b0;
      w_clrSum      = 1'b0;

      case (r_state)
         IDLE, DONE, ERR: begin
            if (r_i_start) begin
               w_stateNext   = REQ;
               w_synNext     = 1'b1;
               w_busyNext    = 1'b1;
               w_doneNext    = 1'b0;
               w_errNext     = 1'b0;
               w_errCodeNext = ERR_NONE;
               w_countNext   = '0;
               w_timerNext   = '0;
               w_clrSum      = 1'b1;
            end
         end

         REQ: begin
            if (r_i_ack) begin
               w_wrEn      = 1'b1;
               w_countNext = r_count + (AWIDTH+1)'(1);
               w_synNext   = 1'b0;
               w_timerNext = '0;
               if (r_i_last) begin
                  w_stateNext = DONE;
                  w_doneNext  = 1'b1;
                  w_busyNext  = 1'b0;
               end else if (w_lastSlot) begin
                  w_stateNext   = ERR;
                  w_errNext     = 1'b1;
                  w_errCodeNext = ERR_OVERFLOW;
                  w_busyNext    = 1'b0;
               end else begin
                  w_stateNext = RELEASE;
               end
            end else if (w_timerExpired) begin
               w_stateNext   = ERR;
               w_errNext     = 1'b1;
               w_errCodeNext = ERR_TIMEOUT;
               w_synNext     = 1'b0;
               w_busyNext    = 1'b0;
            end else begin
               w_timerNext = r_timer + TWIDTH'(1);
            end
         end

         RELEASE: begin
            if (!r_i_ack) begin
               w_stateNext = REQ;
               w_synNext   = 1'b1;
               w_timerNext = '0;
            end else if (w_timerExpired) begin
               w_stateNext   = ERR;
               w_errNext     = 1'b1;
               w_errCodeNext = ERR_TIMEOUT;
               w_synNext     = 1'b0;
               w_busyNext    = 1'b0;
            end else begin
               w_timerNext = r_timer + TWIDTH'(1);
            end
         end

         default: begin
            w_stateNext = IDLE;
            w_synNext   = 1'b0;
            w_busyNext  = 1'b0;
         end
      endcase
   end

   // Registered control outputs and the synchronous read port
   always_ff @(posedge r_clk) begin
      if (r_rst) begin
         r_syn     <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
         r_errCode <= ERR_NONE;
         r_count   <= '0;
         r_timer   <= '0;
         r_rdData  <= '0;
      end else begin
         r_syn     <= w_synNext;
         r_busy    <= w_busyNext;
         r_done    <= w_doneNext;
         r_err     <= w_errNext;
         r_errCode <= w_errCodeNext;
         r_count   <= w_countNext;
         r_timer   <= w_timerNext;
         r_rdData  <= w_addrValid ? r_mem[r_i_rd_addr] : '0;
      end
   end

   // Buffer keeps its contents across reset; a write never exceeds DEPTH-1
   always_ff @(posedge r_clk) begin
      if (!r_rst && w_wrEn) begin
         r_mem[r_count[AWIDTH-1:0]] <= r_i_instr;
      end
   end

`ifdef RECEIVE_CHECKSUM_EN
   logic [IWIDTH-1:0] r_checksum;

   always_ff @(posedge r_clk) begin
      if (r_rst || w_clrSum) begin
         r_checksum <= '0;
      end else if (w_wrEn) begin
         r_checksum <= r_checksum ^ r_i_instr;
      end
   end

   assign r_o_checksum = r_checksum;
`else
   assign r_o_checksum = '0;
`endif

   assign r_o_syn      = r_syn;
   assign r_o_busy     = r_busy;
   assign r_o_done     = r_done;
   assign r_o_err      = r_err;
   assign r_o_err_code = r_errCode;
   assign r_o_count    = r_count;
   assign r_o_rd_data  = r_rdData;

endmodule

// File: tb/tb_instr_receive.sv
// Bench for instr_receive: a default-size instance plus a DEPTH=4 instance for overflow,
// both driven by one transmitter model; read-back data checked through a scoreboard queue.
module tb_instr_receive;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        ack;
   logic        last;
   logic [31:0] instr;
   logic [5:0]  rdAddr;

   logic        syn,  sSyn;
   logic [31:0] rdData, sRdData;
   logic [6:0]  count;
   logic [2:0]  sCount;
   logic        busy, done, err;
   logic        sBusy, sDone, sErr;
   logic [1:0]  errCode, sErrCode;
   logic [31:0] checksum, sChecksum;

   int errors = 0;
   int checks = 0;
   logic [31:0] expQ [$];

   always #5 clk = ~clk;

   instr_receive dut (
      .r_clk(clk), .r_rst(rst), .r_i_start(start), .r_o_syn(syn),
      .r_i_ack(ack), .r_i_last(last), .r_i_instr(instr),
      .r_i_rd_addr(rdAddr), .r_o_rd_data(rdData), .r_o_count(count),
      .r_o_busy(busy), .r_o_done(done), .r_o_err(err),
      .r_o_err_code(errCode), .r_o_checksum(checksum)
   );

   instr_receive #(.DEPTH(4), .AWIDTH(2)) dutSmall (
      .r_clk(clk), .r_rst(rst), .r_i_start(start), .r_o_syn(sSyn),
      .r_i_ack(ack), .r_i_last(last), .r_i_instr(instr),
      .r_i_rd_addr(rdAddr[1:0]), .r_o_rd_data(sRdData), .r_o_count(sCount),
      .r_o_busy(sBusy), .r_o_done(sDone), .r_o_err(sErr),
      .r_o_err_code(sErrCode), .r_o_checksum(sChecksum)
   );

   // One-cycle start pulse, driven from a negedge
   task automatic startPulse();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Transmitter model: wait for syn of the chosen instance, answer with one word, release
   task automatic xferWord(input logic [31:0] w, input logic l, input bit sel);
      int n = 0;
      while (((sel ? sSyn : syn) !== 1'b1) && n < 50) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= 50) begin
         $display("[TB] FAIL synWait: syn never rose for word %h (waited %0d cycles)", w, n);
         errors++;
      end
      ack   = 1'b1;
      instr = w;
      last  = l;
      @(negedge clk);
      ack   = 1'b0;
      last  = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if ({syn, busy, done, err, errCode, count} !== 13'd0) begin
         $display("[TB] FAIL resetFlags: got syn=%b busy=%b done=%b err=%b code=%b count=%0d, want all 0",
                  syn, busy, done, err, errCode, count);
         errors++;
      end
      checks++;
      if (rdData !== 32'd0 || checksum !== 32'd0) begin
         $display("[TB] FAIL resetData: got rdData=%h checksum=%h, want 0", rdData, checksum);
         errors++;
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_full_transfer();
      logic [31:0] exp;
      startPulse();
      for (int i = 0; i < 36; i++) begin
         xferWord(32'(i), (i == 35), 1'b0);
         expQ.push_back(32'(i));
      end
      checks++;
      if (done !== 1'b1 || err !== 1'b0 || busy !== 1'b0 || syn !== 1'b0 || count !== 7'd36) begin
         $display("[TB] FAIL fullStatus: got done=%b err=%b busy=%b syn=%b count=%0d, want 1 0 0 0 36",
                  done, err, busy, syn, count);
         errors++;
      end
      for (int i = 0; i < 36; i++) begin
         rdAddr = 6'(i);
         @(negedge clk);
         exp = expQ.pop_front();
         checks++;
         if (rdData !== exp) begin
            $display("[TB] FAIL readBack[%0d]: got %h, want %h", i, rdData, exp);
            errors++;
         end
      end
      rdAddr = 6'd40;
      @(negedge clk);
      checks++;
      if (rdData !== 32'd0) begin
         $display("[TB] FAIL readOutOfRange: got %h, want 0", rdData);
         errors++;
      end
      rdAddr = 6'd0;
   endtask

   task automatic test_timeout();
      int n = 0;
      startPulse();
      while (syn === 1'b1 && n < 40) begin
         n++;
         @(negedge clk);
      end
      checks++;
      if (n !== 16) begin
         $display("[TB] FAIL timeoutSynCycles: got %0d, want 16", n);
         errors++;
      end
      checks++;
      if (err !== 1'b1 || errCode !== 2'b01 || busy !== 1'b0 || count !== 7'd0 || done !== 1'b0) begin
         $display("[TB] FAIL timeoutStatus: got err=%b code=%b busy=%b count=%0d done=%b, want 1 01 0 0 0",
                  err, errCode, busy, count, done);
         errors++;
      end
   endtask

   task automatic test_overflow();
      logic [31:0] exp;
      startPulse();
      for (int i = 0; i < 4; i++) begin
         xferWord(32'h10 << i, 1'b0, 1'b1);
         expQ.push_back(32'h10 << i);
      end
      checks++;
      if (sErr !== 1'b1 || sErrCode !== 2'b10 || sCount !== 3'd4 || sDone !== 1'b0 || sBusy !== 1'b0) begin
         $display("[TB] FAIL overflowStatus: got err=%b code=%b count=%0d done=%b busy=%b, want 1 10 4 0 0",
                  sErr, sErrCode, sCount, sDone, sBusy);
         errors++;
      end
      checks++;
`ifdef RECEIVE_CHECKSUM_EN
      if (sChecksum !== 32'hF0) begin
`else
      if (sChecksum !== 32'h0) begin
`endif
         $display("[TB] FAIL overflowChecksum: got %h", sChecksum);
         errors++;
      end
      for (int i = 0; i < 4; i++) begin
         rdAddr = 6'(i);
         @(negedge clk);
         exp = expQ.pop_front();
         checks++;
         if (sRdData !== exp) begin
            $display("[TB] FAIL overflowRead[%0d]: got %h, want %h", i, sRdData, exp);
            errors++;
         end
      end
      rdAddr = 6'd0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset_mid();
      startPulse();
      for (int i = 0; i < 10; i++) xferWord(32'hB000_0000 + 32'(i), 1'b0, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (syn !== 1'b0 || busy !== 1'b0 || count !== 7'd0 || done !== 1'b0 || err !== 1'b0) begin
         $display("[TB] FAIL midReset: got syn=%b busy=%b count=%0d done=%b err=%b, want all 0",
                  syn, busy, count, done, err);
         errors++;
      end
      rst = 1'b0;
      @(negedge clk);
      startPulse();
      for (int i = 0; i < 36; i++) xferWord(32'hC000_0000 + 32'(i), (i == 35), 1'b0);
      checks++;
      if (done !== 1'b1 || count !== 7'd36 || err !== 1'b0) begin
         $display("[TB] FAIL afterReset: got done=%b count=%0d err=%b, want 1 36 0", done, count, err);
         errors++;
      end
   endtask

   task automatic test_start_while_busy();
      startPulse();
      checks++;
      if (done !== 1'b0 || count !== 7'd0 || busy !== 1'b1 || syn !== 1'b1) begin
         $display("[TB] FAIL restartAfterDone: got done=%b count=%0d busy=%b syn=%b, want 0 0 1 1",
                  done, count, busy, syn);
         errors++;
      end
      for (int i = 0; i < 4; i++) xferWord(32'hD000_0000 + 32'(i), 1'b0, 1'b0);
      startPulse();
      checks++;
      if (count !== 7'd4 || busy !== 1'b1) begin
         $display("[TB] FAIL startIgnored: got count=%0d busy=%b, want 4 1", count, busy);
         errors++;
      end
      for (int i = 4; i < 36; i++) xferWord(32'hD000_0000 + 32'(i), (i == 35), 1'b0);
      checks++;
      if (done !== 1'b1 || count !== 7'd36) begin
         $display("[TB] FAIL busyComplete: got done=%b count=%0d, want 1 36", done, count);
         errors++;
      end
   endtask

   task automatic test_release_timeout();
      startPulse();
      ack   = 1'b1;
      instr = 32'hE0E0_E0E0;
      repeat (20) @(negedge clk);
      checks++;
      if (err !== 1'b1 || errCode !== 2'b01 || count !== 7'd1 || syn !== 1'b0 || busy !== 1'b0) begin
         $display("[TB] FAIL releaseTimeout: got err=%b code=%b count=%0d syn=%b busy=%b, want 1 01 1 0 0",
                  err, errCode, count, syn, busy);
         errors++;
      end
      ack = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_checksum();
      startPulse();
      xferWord(32'h1, 1'b0, 1'b0);
      xferWord(32'h2, 1'b0, 1'b0);
      xferWord(32'h4, 1'b1, 1'b0);
      checks++;
      if (done !== 1'b1 || count !== 7'd3) begin
         $display("[TB] FAIL checksumXfer: got done=%b count=%0d, want 1 3", done, count);
         errors++;
      end
      checks++;
`ifdef RECEIVE_CHECKSUM_EN
      if (checksum !== 32'h0000_0007) begin
         $display("[TB] FAIL checksum: got %h, want 00000007", checksum);
`else
      if (checksum !== 32'h0) begin
         $display("[TB] FAIL checksum: got %h, want 00000000", checksum);
`endif
         errors++;
      end
   endtask

   initial begin
      rst    = 1'b1;
      start  = 1'b0;
      ack    = 1'b0;
      last   = 1'b0;
      instr  = '0;
      rdAddr = '0;
      @(negedge clk);
      test_reset();
      test_full_transfer();
      test_timeout();
      test_overflow();
      test_reset_mid();
      test_start_while_busy();
      test_release_timeout();
      test_checksum();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/instr_receive.md
Name: instr_receive

Overview:
- Downstream consumer of the instruction transmit stage.
- Requests words one at a time via a syn/ack handshake and captures each word into a local DEPTH-entry instruction buffer.
- Flags completion when the transmitter marks the final word (last), and flags an error on handshake timeout or buffer overflow.
- Downstream logic (decode/fetch) reads the buffer through a synchronous read port.

Parameters:
- IWIDTH, 32, instruction word width.
- DEPTH, 36, buffer entries; maximum words per transfer.
- AWIDTH, 6, buffer address width; 2^AWIDTH >= DEPTH required.
- TIMEOUT, 16, max consecutive cycles waiting on an ack edge before error; >= 2.

Ports:
- r_clk  in  1  clock, all logic on rising edge.
- r_rst  in  1  synchronous, active-high reset.
- r_i_start  in  1  pulse; begin a transfer (ignored while busy).
- r_o_syn  out  1  request to transmitter (connects to t_i_syn).
- r_i_ack  in  1  transmitter ack; word valid while high.
- r_i_last  in  1  final-word marker, qualified by r_i_ack.
- r_i_instr  in  IWIDTH  instruction word, qualified by r_i_ack.
- r_i_rd_addr  in  AWIDTH  buffer read address.
- r_o_rd_data  out  IWIDTH  buffer read data, 1-cycle latency.
- r_o_count  out  AWIDTH+1  words captured in current/last transfer.
- r_o_busy  out  1  transfer in progress.
- r_o_done  out  1  transfer completed via last; sticky.
- r_o_err  out  1  transfer aborted; sticky.
- r_o_err_code  out  2  01 timeout, 10 overflow, 00 none.
- r_o_checksum  out  IWIDTH  see Optional Feature.

Behaviour:
- All outputs registered. Reset values: syn 0, count 0, busy 0, done 0, err 0, err_code 00, rd_data 0, checksum 0.
- Buffer contents are not reset.
- FSM states: IDLE, REQ, RELEASE, DONE, ERR. Reset -> IDLE.
- IDLE / DONE / ERR:
  - start sampled high -> REQ next edge.
  - On that edge: syn=1, busy=1, count=0, done=0, err=0, err_code=00, timer=0.
- REQ: syn held 1.
  - ack sampled 1 -> write mem[count]=r_i_instr, count+1, syn=0.
  - Then: last=1 -> DONE (done=1, busy=0). Else if count+1 == DEPTH -> ERR code 10. Else -> RELEASE.
- RELEASE: syn=0; wait for ack sampled 0, then -> REQ with syn=1 (four-phase handshake).
- Timer: clears on each entry to REQ or RELEASE and increments each cycle the awaited condition is false. Reaching TIMEOUT -> ERR code 01, syn=0, busy=0.
- Minimum cost per word: 2 cycles (REQ, RELEASE) when ack responds immediately.
- Simultaneous events:
  - ack and timer expiry in the same cycle: ack wins.
  - last on word DEPTH (count DEPTH-1 -> DEPTH): DONE, not overflow.
  - start while busy: ignored.
  - last without ack: ignored.
- Reset mid-transfer: next edge forces IDLE, syn 0, count 0, all flags cleared; partial buffer data is left as is.
- Read port: r_o_rd_data <= mem[r_i_rd_addr] every edge, independent of FSM state. Addresses >= DEPTH return 0. Data for addresses >= count is undefined.
- A write and a read to the same address on the same edge return old data.

Optional Feature:
- Macro RECEIVE_CHECKSUM_EN.
- Defined: r_o_checksum = running XOR of every captured word. Cleared at reset and on accepted start; updated on the same edge as each buffer write; holds after DONE/ERR.
- Undefined: r_o_checksum tied to 0 and no XOR logic synthesised.

Test Plan:
- Full transfer: start; transmitter answers 36 requests with words 0x00000000..0x00000023, last on the 36th -> done=1, err=0, count=36; reading addr 0..35 returns the matching word one cycle after each address.
- Timeout: start with ack held 0 -> syn=1 for exactly 16 cycles, then err=1, err_code=01, syn=0, busy=0, count=0.
- Overflow: DEPTH=4, transmitter never asserts last -> after 4 words err_code=10, count=4, done=0.
- Reset mid-transfer: assert r_rst after word 10 -> next cycle syn=0, busy=0, count=0; new start completes normally with count=36.
- Start while busy: pulse start during word 5 -> no count reset, transfer completes with count=36; start after DONE clears done and restarts from count 0.
- Checksum (RECEIVE_CHECKSUM_EN): words 0x1, 0x2, 0x4, last on the 3rd -> checksum=0x00000007. Without the macro, checksum stays 0.
